// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - UART byte frames to 32-bit peri-bus write/read transactions
// Optional CHK byte after the payload when UART_BM_CHKSUM_EN is defined.
module uart_bus_master #(
  parameter int RD_TIMEOUT = 256,
  parameter int RX_TIMEOUT = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_8b,
  input  logic        i_rx_valid,
  output logic [7:0]  o_tx_8b,
  output logic        o_tx_valid,
  input  logic        i_tx_busy,
  output logic [31:0] o_addr_32b,
  output logic        o_wren,
  output logic        o_rden,
  output logic [31:0] o_din_32b,
  input  logic [31:0] i_dout_32b,
  input  logic        i_dout_32b_valid,
  output logic        o_busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHK    = 3'd4;
  localparam logic [2:0] S_BUS    = 3'd5;
  localparam logic [2:0] S_RDWAIT = 3'd6;
  localparam logic [2:0] S_RESP   = 3'd7;

`ifdef UART_BM_CHKSUM_EN
  localparam logic [2:0] S_AFTER_PAYLOAD = S_CHK;
`else
  localparam logic [2:0] S_AFTER_PAYLOAD = S_BUS;
`endif

  localparam logic [23:0] RX_LIMIT = 24'(RX_TIMEOUT - 1);
  localparam logic [15:0] RD_LIMIT = 16'(RD_TIMEOUT);

  logic [2:0]  state;
  logic        is_read;
  logic [1:0]  byte_cnt;
  logic [31:0] addr_sr;
  logic [31:0] data_sr;
  logic [7:0]  chk_acc;
  logic [23:0] idle_cnt;
  logic [15:0] rd_cnt;
  logic [39:0] resp_sr;
  logic [2:0]  resp_left;
  logic        tx_gap;

  // Response bytes leave from the top of resp_sr; a pulse is only offered while the transmitter is free.
  assign o_tx_valid = (state == S_RESP) && !tx_gap && !i_tx_busy;
  assign o_tx_8b    = resp_sr[39:32];
  assign o_busy     = (state != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      is_read    <= 1'b0;
      byte_cnt   <= 2'd0;
      addr_sr    <= 32'd0;
      data_sr    <= 32'd0;
      chk_acc    <= 8'd0;
      idle_cnt   <= 24'd0;
      rd_cnt     <= 16'd0;
      resp_sr    <= 40'd0;
      resp_left  <= 3'd0;
      tx_gap     <= 1'b0;
      o_addr_32b <= 32'd0;
      o_din_32b  <= 32'd0;
      o_wren     <= 1'b0;
      o_rden     <= 1'b0;
    end else begin
      o_wren <= 1'b0;
      o_rden <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_rx_valid && i_rx_8b == 8'hA5) begin
            state    <= S_CMD;
            idle_cnt <= 24'd0;
            chk_acc  <= 8'd0;
            byte_cnt <= 2'd0;
          end
        end
        S_CMD, S_ADDR, S_DATA, S_CHK: begin
          if (!i_rx_valid) begin
            if (idle_cnt == RX_LIMIT) state <= S_IDLE;
            else idle_cnt <= idle_cnt + 24'd1;
          end else begin
            idle_cnt <= 24'd0;
            chk_acc  <= chk_acc ^ i_rx_8b;
            byte_cnt <= byte_cnt + 2'd1;
            case (state)
              S_CMD: begin
                if (i_rx_8b == 8'h01 || i_rx_8b == 8'h02) begin
                  is_read  <= (i_rx_8b == 8'h02);
                  byte_cnt <= 2'd0;
                  state    <= S_ADDR;
                end else begin
                  resp_sr   <= {8'h5A, 8'hEC, 24'd0};
                  resp_left <= 3'd2;
                  tx_gap    <= 1'b0;
                  state     <= S_RESP;
                end
              end
              S_ADDR: begin
                addr_sr <= {addr_sr[23:0], i_rx_8b};
                if (byte_cnt == 2'd3) state <= is_read ? S_AFTER_PAYLOAD : S_DATA;
              end
              S_DATA: begin
                data_sr <= {data_sr[23:0], i_rx_8b};
                if (byte_cnt == 2'd3) state <= S_AFTER_PAYLOAD;
              end
              default: begin
                if (i_rx_8b == chk_acc) begin
                  state <= S_BUS;
                end else begin
                  resp_sr   <= {8'h5A, 8'hCE, 24'd0};
                  resp_left <= 3'd2;
                  tx_gap    <= 1'b0;
                  state     <= S_RESP;
                end
              end
            endcase
          end
        end
        S_BUS: begin
          o_addr_32b <= addr_sr;
          if (is_read) begin
            o_rden <= 1'b1;
            rd_cnt <= 16'd0;
            state  <= S_RDWAIT;
          end else begin
            o_din_32b <= data_sr;
            o_wren    <= 1'b1;
            resp_sr   <= {8'h5A, 8'h01, 24'd0};
            resp_left <= 3'd2;
            tx_gap    <= 1'b0;
            state     <= S_RESP;
          end
        end
        S_RDWAIT: begin
          // rd_cnt is 0 in the o_rden cycle, so valid is accepted up to RD_TIMEOUT cycles after it.
          if (i_dout_32b_valid) begin
            resp_sr   <= {8'h5A, i_dout_32b};
            resp_left <= 3'd5;
            tx_gap    <= 1'b0;
            state     <= S_RESP;
          end else if (rd_cnt == RD_LIMIT) begin
            resp_sr   <= {8'h5A, 8'hEE, 24'd0};
            resp_left <= 3'd2;
            tx_gap    <= 1'b0;
            state     <= S_RESP;
          end else begin
            rd_cnt <= rd_cnt + 16'd1;
          end
        end
        default: begin
          tx_gap <= o_tx_valid;
          if (o_tx_valid) begin
            resp_sr   <= {resp_sr[31:0], 8'd0};
            resp_left <= resp_left - 3'd1;
            if (resp_left == 3'd1) state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
